// File: rtl/onehot_pkg.sv
// onehot_pkg: shared definitions for the one-hot stream decoder.
//   buf_state_t      - occupancy state of the 2-entry skid buffer
//   MAX_WIDTH        - widest one-hot vector the helpers can build
//   pos_to_onehot()  - position code to one-hot vector
//                      (returns MAX_WIDTH bits; callers size-cast to WIDTH)
//   pos_out_of_range() - true for a real (non-none) code at or above width
package onehot_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam int unsigned MAX_WIDTH = 64;

  // Codes at or above width decode to all-zero rather than wrapping.
  function automatic logic [MAX_WIDTH-1:0] pos_to_onehot(input int unsigned pos,
                                                         input logic        none,
                                                         input int unsigned width);
    logic [MAX_WIDTH-1:0] vec;
    vec = '0;
    if (!none && (pos < width) && (pos < MAX_WIDTH)) begin
      vec = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << pos;
    end
    return vec;
  endfunction

  function automatic logic pos_out_of_range(input int unsigned pos,
                                            input logic        none,
                                            input int unsigned width);
    return !none && (pos >= width);
  endfunction

endpackage

// File: rtl/onehot_skid_buf.sv
// onehot_skid_buf: 2-entry valid/ready skid buffer with registered outputs.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid/in_ready     - upstream handshake (in_ready is a register)
//   in_data [WIDTH]       - beat to store
//   out_valid/out_ready   - downstream handshake
//   out_data [WIDTH]      - main register contents
module onehot_skid_buf
  import onehot_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_t       state;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             emit;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // in_ready is computed from the next state so it never depends
  // combinationally on out_ready; it defaults to 1 and is pulled low only
  // when the buffer is (or becomes) FULL. It resets to 0 so the upstream
  // sees no ready while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      in_ready <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= FULL;
          end else if (emit) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            out_data <= skid_data;
            state    <= ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/onehot_stream_decoder.sv
// onehot_stream_decoder: streaming position-code to one-hot decoder.
// Optional feature macro: ONEHOT_STREAM_DECODER_ERR_EN (sticky err flag for
// out-of-range codes); when undefined err is tied to 0.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid/in_ready     - input handshake (in_ready registered)
//   in_pos [POS_W]        - bit position to set
//   in_none               - emit an all-zero vector, ignore in_pos
//   out_valid/out_ready   - output handshake
//   out_onehot [WIDTH]    - decoded vector
//   err                   - sticky out-of-range flag
module onehot_stream_decoder
  import onehot_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic             in_none,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic             err
);

  logic [WIDTH-1:0] decoded;

  assign decoded = WIDTH'(pos_to_onehot(32'(in_pos), in_none, WIDTH));

  onehot_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (decoded),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_onehot)
  );

`ifdef ONEHOT_STREAM_DECODER_ERR_EN
  logic err_q;

  // Sticky: any accepted out-of-range code latches err until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (in_valid && in_ready && pos_out_of_range(32'(in_pos), in_none, WIDTH)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_stream_decoder.sv
// tb_onehot_stream_decoder: scoreboard bench for onehot_stream_decoder
// (WIDTH=5 so out-of-range codes 5..7 are reachable). Expected err behaviour
// follows ONEHOT_STREAM_DECODER_ERR_EN.
module tb_onehot_stream_decoder;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned POS_W = 3;
`ifdef ONEHOT_STREAM_DECODER_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [POS_W-1:0] in_pos = '0;
  logic             in_none = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_onehot;
  logic             err;

  int               total = 0;
  int               bad = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             err_exp = 1'b0;
  logic             rst_hold = 1'b1;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_val = '0;
  int               accepted = 0;

  onehot_stream_decoder #(
    .WIDTH(WIDTH),
    .POS_W(POS_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_none   (in_none),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_onehot(out_onehot),
    .err       (err)
  );

  always #5 clk = ~clk;

  // in_ready is expected low until the first clock edge after reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) rst_hold <= 1'b1;
    else       rst_hold <= 1'b0;
  end

  // Reference decode straight from the rule: 2**pos for in-range codes.
  function automatic logic [WIDTH-1:0] model_decode(input int unsigned pos, input logic none);
    int unsigned val;
    val = 0;
    if (!none && pos < WIDTH) val = 2 ** pos;
    return WIDTH'(val);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; a beat seen accepted is pushed to the scoreboard
  // just before the edge that actually takes it.
  task automatic applyStimulus(input logic v, input int unsigned pos, input logic none,
                               input logic ordy, output logic acc);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_pos    = POS_W'(pos);
    in_none   = none;
    out_ready = ordy;
    @(negedge clk);
    #1;
    acc = in_valid && in_ready && !reset;
    if (acc) begin
      exp_q.push_back(model_decode(pos, none));
      if (ERR_ON && !none && pos >= WIDTH) err_exp = 1'b1;
      accepted++;
    end
  endtask

  // Monitor: occupancy-based handshake expectations, ordered data compare,
  // and hold-while-stalled checks.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_val;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      checkOutput("in_ready", 32'(in_ready), 32'(!rst_hold && exp_q.size() < 2));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      checkOutput("err", 32'(err), 32'(err_exp));
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'(out_onehot), 32'(prev_val));
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL extra_beat: got %0h expected none at %0t", out_onehot, $time);
        end else begin
          exp_val = exp_q.pop_front();
          total--;
          checkOutput("data", 32'(out_onehot), 32'(exp_val));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_val   = out_onehot;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    int   cycles;

    // Power-on reset
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_onehot", 32'(out_onehot), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    applyStimulus(1'b0, 0, 1'b0, 1'b1, acc);
    checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

    // Back-to-back positions, full throughput
    for (int p = 0; p < 5; p++) applyStimulus(1'b1, p, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 3, 1'b1, 1'b1, acc);
    repeat (2) applyStimulus(1'b0, 0, 1'b0, 1'b1, acc);

    // Backpressure: two beats fill the buffer, further beats are refused
    applyStimulus(1'b1, 1, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 2, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 3, 1'b0, 1'b0, acc);
    checkOutput("bp_ready_low", 32'(in_ready), 32'd0);
    checkOutput("bp_hold", 32'(out_onehot), 32'h02);
    applyStimulus(1'b1, 3, 1'b0, 1'b0, acc);
    repeat (4) applyStimulus(1'b0, 0, 1'b0, 1'b1, acc);
    checkOutput("bp_ready_back", 32'(in_ready), 32'd1);

    // Out-of-range code, then idle to confirm err is sticky
    applyStimulus(1'b1, 6, 1'b0, 1'b1, acc);
    repeat (11) applyStimulus(1'b0, 0, 1'b0, 1'b1, acc);
    checkOutput("err_sticky", 32'(err), 32'(ERR_ON));

    // Asynchronous reset while FULL
    applyStimulus(1'b1, 0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 4, 1'b0, 1'b0, acc);
    @(posedge clk);
    #3;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_onehot", 32'(out_onehot), 32'd0);
    checkOutput("async_err", 32'(err), 32'd0);
    exp_q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (4) applyStimulus(1'b0, 0, 1'b0, 1'b1, acc);

    // Random traffic
    accepted = 0;
    cycles   = 0;
    while (accepted < 10000 && cycles < 60000) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, acc);
      cycles++;
    end
    checkOutput("random_beats", 32'(accepted >= 10000), 32'd1);

    // Drain
    repeat (5) applyStimulus(1'b0, 0, 1'b0, 1'b1, acc);
    checkOutput("drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
